// File: rtl/spi_slave_regif.sv
`timescale 1ns/1ps
// spi_slave_regif: SPI slave (modes 0..3) that decodes a R/W + address header
// byte followed by DATA_BYTES-wide data words, and turns them into single-cycle
// register-file read/write strobes on the system clock. Bursts auto-increment
// the word address.
module spi_slave_regif #(
  parameter int ADD_range  = 7,
  parameter int DATA_BYTES = 3,
  parameter int SPI_MODE   = 0
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      SCA_spi,
  input  logic                      CS_spi,
  input  logic                      MOSI_spi,
  output logic                      MISO_spi,
  output logic [ADD_range-1:0]      reg_addr,
  output logic [8*DATA_BYTES-1:0]   reg_wdata,
  output logic                      reg_wr,
  output logic                      reg_rd,
  input  logic [8*DATA_BYTES-1:0]   reg_rdata,
  output logic                      busy,
  output logic                      frame_err
);

  localparam int DW   = 8 * DATA_BYTES;
  localparam int CW   = $clog2(DW);
  localparam bit CPOL = SPI_MODE[1];
  localparam bit CPHA = SPI_MODE[0];

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_HEADER = 2'd1,
    ST_WDATA  = 2'd2,
    ST_RDATA  = 2'd3
  } state_t;

  state_t                 state_r, state_nx;
  logic                   sck_meta_r, sck_sync_r, sck_prev_r;
  logic                   cs_meta_r, cs_sync_r, cs_prev_r;
  logic                   mosi_meta_r, mosi_sync_r;
  logic [CW-1:0]          bit_cnt_r;
  logic [ADD_range-1:0]   hdr_r;
  logic [DW-2:0]          wsr_r;
  logic [DW-1:0]          rsr_r;
  logic                   rd_first_r, rd_dly_r, addr_inc_r;
  logic                   miso_r, reg_wr_r, reg_rd_r, busy_r, frame_err_r;
  logic [ADD_range-1:0]   reg_addr_r;
  logic [DW-1:0]          reg_wdata_r;

  logic                   sck_rise_s, sck_fall_s, lead_s, trail_s, sample_s, shift_s;
  logic                   cs_fall_s, cs_rise_s;
  logic [ADD_range:0]     hdr_nx_s;
  logic [DW-1:0]          wsr_nx_s;
  logic                   hdr_done_s, word_done_s, abort_s;

  // Edge decode of the synchronised SPI clock and chip select.
  assign sck_rise_s = sck_sync_r & ~sck_prev_r;
  assign sck_fall_s = ~sck_sync_r & sck_prev_r;
  assign lead_s     = CPOL ? sck_fall_s : sck_rise_s;
  assign trail_s    = CPOL ? sck_rise_s : sck_fall_s;
  assign sample_s   = CPHA ? trail_s : lead_s;
  assign shift_s    = CPHA ? lead_s : trail_s;
  assign cs_fall_s  = cs_prev_r & ~cs_sync_r;
  assign cs_rise_s  = ~cs_prev_r & cs_sync_r;
  assign hdr_nx_s   = {hdr_r, mosi_sync_r};
  assign wsr_nx_s   = {wsr_r, mosi_sync_r};

  assign MISO_spi  = miso_r;
  assign reg_addr  = reg_addr_r;
  assign reg_wdata = reg_wdata_r;
  assign reg_wr    = reg_wr_r;
  assign reg_rd    = reg_rd_r;
  assign busy      = busy_r;
  assign frame_err = frame_err_r;

  // Two-flop synchronisers for the asynchronous SPI pins plus edge-detect history.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sck_meta_r  <= CPOL;
      sck_sync_r  <= CPOL;
      sck_prev_r  <= CPOL;
      cs_meta_r   <= 1'b1;
      cs_sync_r   <= 1'b1;
      cs_prev_r   <= 1'b1;
      mosi_meta_r <= 1'b0;
      mosi_sync_r <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      sck_meta_r  <= SCA_spi;
      sck_sync_r  <= sck_meta_r;
      sck_prev_r  <= sck_sync_r;
      cs_meta_r   <= CS_spi;
      cs_sync_r   <= cs_meta_r;
      cs_prev_r   <= cs_sync_r;
      mosi_meta_r <= MOSI_spi;
      mosi_sync_r <= mosi_meta_r;
      busy_r      <= ~cs_meta_r;
    end
  end

  // Frame state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nx;
    end
  end

  // Next-state logic; a chip-select release always wins over a coincident sample.
  always_comb begin
    state_nx    = state_r;
    hdr_done_s  = 1'b0;
    word_done_s = 1'b0;
    abort_s     = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (cs_fall_s) begin
          state_nx = ST_HEADER;
        end else begin
          state_nx = ST_IDLE;
        end
      end
      ST_HEADER: begin
        if (cs_rise_s) begin
          state_nx = ST_IDLE;
          abort_s  = (bit_cnt_r != CW'(0));
        end else if (sample_s && (bit_cnt_r == CW'(7))) begin
          hdr_done_s = 1'b1;
          if (hdr_nx_s[ADD_range]) begin
            state_nx = ST_WDATA;
          end else begin
            state_nx = ST_RDATA;
          end
        end else begin
          state_nx = ST_HEADER;
        end
      end
      ST_WDATA, ST_RDATA: begin
        if (cs_rise_s) begin
          state_nx = ST_IDLE;
          abort_s  = (bit_cnt_r != CW'(0));
        end else if (sample_s && (bit_cnt_r == CW'(DW - 1))) begin
          word_done_s = 1'b1;
        end else begin
          state_nx = state_r;
        end
      end
      default: begin
        state_nx = ST_IDLE;
      end
    endcase
  end

  // Shift registers, bit counter, address, strobes and MISO driver.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bit_cnt_r   <= CW'(0);
      hdr_r       <= {ADD_range{1'b0}};
      wsr_r       <= {(DW-1){1'b0}};
      rsr_r       <= {DW{1'b0}};
      rd_first_r  <= 1'b0;
      rd_dly_r    <= 1'b0;
      addr_inc_r  <= 1'b0;
      miso_r      <= 1'b0;
      reg_wr_r    <= 1'b0;
      reg_rd_r    <= 1'b0;
      frame_err_r <= 1'b0;
      reg_addr_r  <= {ADD_range{1'b0}};
      reg_wdata_r <= {DW{1'b0}};
    end else begin
      reg_wr_r    <= 1'b0;
      reg_rd_r    <= 1'b0;
      frame_err_r <= 1'b0;
      addr_inc_r  <= 1'b0;
      rd_dly_r    <= reg_rd_r;
      if (addr_inc_r) begin
        reg_addr_r <= reg_addr_r + ADD_range'(1);
      end
      case (state_r)
        ST_IDLE: begin
          bit_cnt_r  <= CW'(0);
          hdr_r      <= {ADD_range{1'b0}};
          wsr_r      <= {(DW-1){1'b0}};
          rsr_r      <= {DW{1'b0}};
          rd_first_r <= 1'b0;
        end
        ST_HEADER: begin
          if (cs_rise_s) begin
            bit_cnt_r   <= CW'(0);
            frame_err_r <= abort_s;
          end else if (sample_s) begin
            hdr_r <= hdr_nx_s[ADD_range-1:0];
            if (hdr_done_s) begin
              bit_cnt_r  <= CW'(0);
              reg_addr_r <= hdr_nx_s[ADD_range-1:0];
              reg_rd_r   <= ~hdr_nx_s[ADD_range];
            end else begin
              bit_cnt_r <= bit_cnt_r + CW'(1);
            end
          end
        end
        ST_WDATA: begin
          if (cs_rise_s) begin
            bit_cnt_r   <= CW'(0);
            frame_err_r <= abort_s;
          end else if (sample_s) begin
            wsr_r <= wsr_nx_s[DW-2:0];
            if (word_done_s) begin
              reg_wdata_r <= wsr_nx_s;
              reg_wr_r    <= 1'b1;
              addr_inc_r  <= 1'b1;
              bit_cnt_r   <= CW'(0);
            end else begin
              bit_cnt_r <= bit_cnt_r + CW'(1);
            end
          end
        end
        ST_RDATA: begin
          if (cs_rise_s) begin
            bit_cnt_r   <= CW'(0);
            frame_err_r <= abort_s;
          end else begin
            if (sample_s) begin
              if (word_done_s) begin
                bit_cnt_r  <= CW'(0);
                reg_addr_r <= reg_addr_r + ADD_range'(1);
                reg_rd_r   <= 1'b1;
              end else begin
                bit_cnt_r <= bit_cnt_r + CW'(1);
              end
            end
            // Load happens before the next shift edge; the first shift edge
            // after a load only exposes the MSB (mode 0/2 already shows it).
            if (rd_dly_r) begin
              rsr_r      <= reg_rdata;
              rd_first_r <= 1'b1;
              if (!CPHA) begin
                miso_r <= reg_rdata[DW-1];
              end
            end else if (shift_s) begin
              if (rd_first_r) begin
                rd_first_r <= 1'b0;
                miso_r     <= rsr_r[DW-1];
              end else begin
                rsr_r  <= {rsr_r[DW-2:0], 1'b0};
                miso_r <= rsr_r[DW-2];
              end
            end
          end
        end
        default: begin
          bit_cnt_r <= CW'(0);
        end
      endcase
      if (state_nx != ST_RDATA) begin
        miso_r <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_spi_slave_regif.sv
`timescale 1ns/1ps
// Bench for spi_slave_regif: seven instances covering all SPI modes and word
// widths, driven by a bit-level SPI master and checked against a simple
// frame-level model (address arithmetic modulo 128, register-file array).
module tb_spi_slave_regif;

  localparam int NI   = 7;
  localparam int HALF = 80;

  // Instance configuration: 0 = mode 0 / 3 bytes, then modes 1..3 with 1 and 4 bytes.
  function automatic int cfg_mode(input int i);
    case (i)
      1, 2:    return 1;
      3, 4:    return 2;
      5, 6:    return 3;
      default: return 0;
    endcase
  endfunction

  function automatic int cfg_db(input int i);
    if (i == 0) return 3;
    else if ((i % 2) == 1) return 1;
    else return 4;
  endfunction

  function automatic logic [31:0] dmask(input int dw);
    logic [63:0] m;
    m = (64'd1 << dw) - 64'd1;
    return m[31:0];
  endfunction

  typedef struct packed {
    logic [3:0]  inst;
    logic [6:0]  addr;
    logic [31:0] data;
  } ev_t;

  logic            clk, reset, sck, mosi;
  logic [NI-1:0]   cs, miso_a, wr_a, rd_a, busy_a, err_a;
  logic [6:0]      addr_a  [NI];
  logic [31:0]     wdata_a [NI];
  logic [31:0]     mem     [128];
  ev_t             wr_log[$];
  ev_t             rd_log[$];
  int              err_cnt   = 0;
  int              clash_cnt = 0;
  logic [NI-1:0]   wr_q = '0;
  logic [NI-1:0]   rd_q = '0;
  bit              tx_q[$];
  bit              rx_q[$];
  logic [31:0]     wq[$];
  int              n_checks = 0;
  int              n_fail   = 0;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    localparam int DB  = cfg_db(g);
    localparam int DWG = 8 * DB;
    logic [DWG-1:0] wd;
    logic [DWG-1:0] rdat;
    assign wdata_a[g] = 32'(wd);
    assign rdat       = mem[addr_a[g]][DWG-1:0];
    spi_slave_regif #(.ADD_range(7), .DATA_BYTES(DB), .SPI_MODE(cfg_mode(g))) u_dut (
      .clk(clk), .reset(reset), .SCA_spi(sck), .CS_spi(cs[g]), .MOSI_spi(mosi),
      .MISO_spi(miso_a[g]), .reg_addr(addr_a[g]), .reg_wdata(wd), .reg_wr(wr_a[g]),
      .reg_rd(rd_a[g]), .reg_rdata(rdat), .busy(busy_a[g]), .frame_err(err_a[g])
    );
  end

  always #5 clk = ~clk;

  // Strobe monitor: logs every strobe and error pulse, counts overlapping/wide strobes.
  always @(negedge clk) begin
    int ne, nc;
    ne = err_cnt;
    nc = clash_cnt;
    for (int i = 0; i < NI; i++) begin
      if (wr_a[i]) wr_log.push_back('{4'(i), addr_a[i], wdata_a[i]});
      if (rd_a[i]) rd_log.push_back('{4'(i), addr_a[i], 32'd0});
      if (err_a[i]) ne++;
      if ((wr_a[i] && rd_a[i]) || (wr_a[i] && wr_q[i]) || (rd_a[i] && rd_q[i])) nc++;
    end
    err_cnt   <= ne;
    clash_cnt <= nc;
    wr_q      <= wr_a;
    rd_q      <= rd_a;
  end

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic push_word(input logic [31:0] w, input int dw);
    for (int b = dw - 1; b >= 0; b--) tx_q.push_back(w[b]);
  endtask

  // Bit-level SPI master for the selected instance; records MISO at each sample edge.
  task automatic spi_frame(input int idx, input bit raise_cs);
    int  m;
    bit  cpol, cpha;
    m    = cfg_mode(idx);
    cpol = ((m >> 1) & 1) != 0;
    cpha = (m & 1) != 0;
    rx_q.delete();
    @(negedge clk);
    #2;
    sck = cpol;
    #(HALF);
    cs[idx] = 1'b0;
    #(HALF);
    check_val("busy_on", 64'(busy_a[idx]), 64'd1);
    foreach (tx_q[k]) begin
      if (!cpha) begin
        mosi = tx_q[k];
        #(HALF);
        sck = ~cpol;
        rx_q.push_back(miso_a[idx]);
        #(HALF);
        sck = cpol;
      end else begin
        sck  = ~cpol;
        mosi = tx_q[k];
        #(HALF);
        sck = cpol;
        rx_q.push_back(miso_a[idx]);
        #(HALF);
      end
    end
    if (!cpha) #(HALF);
    if (raise_cs) begin
      cs[idx] = 1'b1;
      #(2 * HALF);
    end
  endtask

  // Write frame of the words in wq starting at address a.
  task automatic do_write(input int idx, input logic [6:0] a);
    int dw, nw, wb, rb, eb;
    logic any;
    logic [6:0] ea;
    dw = 8 * cfg_db(idx);
    nw = wq.size();
    tx_q.delete();
    push_word({24'd0, 1'b1, a}, 8);
    foreach (wq[k]) push_word(wq[k], dw);
    wb = wr_log.size();
    rb = rd_log.size();
    eb = err_cnt;
    spi_frame(idx, 1'b1);
    check_val("wr_count", 64'(wr_log.size() - wb), 64'(nw));
    for (int k = 0; k < nw && (wb + k) < wr_log.size(); k++) begin
      ea = a + 7'(k);
      check_val("wr_inst", 64'(wr_log[wb+k].inst), 64'(idx));
      check_val("wr_addr", 64'(wr_log[wb+k].addr), 64'(ea));
      check_val("wr_data", 64'(wr_log[wb+k].data), 64'(wq[k]));
    end
    check_val("wr_no_rd", 64'(rd_log.size() - rb), 64'd0);
    check_val("wr_frame_err", 64'(err_cnt - eb), 64'd0);
    any = 1'b0;
    foreach (rx_q[k]) any |= rx_q[k];
    check_val("wr_miso_idle", 64'(any), 64'd0);
    check_val("busy_off", 64'(busy_a[idx]), 64'd0);
  endtask

  // Read burst of nw words from address a; one extra prefetch strobe follows the last word.
  task automatic do_read(input int idx, input logic [6:0] a, input int nw);
    int dw, wb, rb, eb;
    logic any;
    logic [6:0]  ea;
    logic [31:0] got, msk;
    dw  = 8 * cfg_db(idx);
    msk = dmask(dw);
    tx_q.delete();
    push_word({24'd0, 1'b0, a}, 8);
    for (int k = 0; k < nw; k++) push_word($urandom & msk, dw);
    wb = wr_log.size();
    rb = rd_log.size();
    eb = err_cnt;
    spi_frame(idx, 1'b1);
    check_val("rd_count", 64'(rd_log.size() - rb), 64'(nw + 1));
    for (int k = 0; k <= nw && (rb + k) < rd_log.size(); k++) begin
      ea = a + 7'(k);
      check_val("rd_inst", 64'(rd_log[rb+k].inst), 64'(idx));
      check_val("rd_addr", 64'(rd_log[rb+k].addr), 64'(ea));
    end
    for (int k = 0; k < nw; k++) begin
      ea  = a + 7'(k);
      got = 32'd0;
      for (int b = 0; b < dw; b++) got = {got[30:0], rx_q[8 + k*dw + b]};
      check_val("rd_data", 64'(got), 64'(mem[ea] & msk));
    end
    any = 1'b0;
    for (int b = 0; b < 8; b++) any |= rx_q[b];
    check_val("rd_miso_hdr", 64'(any), 64'd0);
    check_val("rd_no_wr", 64'(wr_log.size() - wb), 64'd0);
    check_val("rd_frame_err", 64'(err_cnt - eb), 64'd0);
  endtask

  initial begin
    int wb, eb, nw;
    logic [6:0] a;
    clk   = 1'b0;
    sck   = 1'b0;
    mosi  = 1'b0;
    cs    = '1;
    reset = 1'b1;
    for (int i = 0; i < 128; i++) mem[i] = $urandom;
    #1;
    reset = 1'b0;
    #30;
    for (int i = 0; i < NI; i++) begin
      check_val("reset_state", 64'({miso_a[i], addr_a[i], wdata_a[i], wr_a[i], rd_a[i],
                                    busy_a[i], err_a[i]}), 64'd0);
    end
    #7;
    reset = 1'b1;
    repeat (5) @(posedge clk);

    // Mode 0 single write: frame AA AA AA AA.
    wq.delete();
    wq.push_back(32'h00AAAAAA);
    do_write(0, 7'h2A);

    // Mode 0 read of a known word.
    mem[7'h15] = 32'h00C3A55A;
    do_read(0, 7'h15, 1);

    // Burst write wrapping from 0x7F to 0x00.
    wq.delete();
    wq.push_back(32'h00010203);
    wq.push_back(32'h00040506);
    do_write(0, 7'h7F);

    // Burst read wrapping from 0x7F to 0x00.
    do_read(0, 7'h7F, 2);

    // Abort after 12 data bits of a write.
    tx_q.delete();
    push_word({24'd0, 8'hC4}, 8);
    push_word(32'($urandom_range(0, 4095)), 12);
    wb = wr_log.size();
    eb = err_cnt;
    spi_frame(0, 1'b1);
    check_val("abort_no_wr", 64'(wr_log.size() - wb), 64'd0);
    check_val("abort_frame_err", 64'(err_cnt - eb), 64'd1);
    check_val("abort_idle", 64'(busy_a[0]), 64'd0);
    wq.delete();
    wq.push_back($urandom & dmask(24));
    do_write(0, 7'h11);

    // Asynchronous reset in the middle of the write data phase.
    tx_q.delete();
    push_word({24'd0, 8'h85}, 8);
    push_word(32'($urandom_range(0, 1023)), 10);
    wb = wr_log.size();
    eb = err_cnt;
    spi_frame(0, 1'b0);
    check_val("midreset_busy_before", 64'(busy_a[0]), 64'd1);
    #3;
    reset = 1'b0;
    #1;
    check_val("midreset_state", 64'({miso_a[0], addr_a[0], wdata_a[0], wr_a[0], rd_a[0],
                                      busy_a[0], err_a[0]}), 64'd0);
    cs[0] = 1'b1;
    repeat (10) @(posedge clk);
    #2;
    reset = 1'b1;
    repeat (10) @(posedge clk);
    check_val("midreset_no_wr", 64'(wr_log.size() - wb), 64'd0);
    check_val("midreset_no_err", 64'(err_cnt - eb), 64'd0);
    wq.delete();
    wq.push_back($urandom & dmask(24));
    do_write(0, 7'h05);

    // Every other mode and width: random write and read bursts.
    for (int i = 1; i < NI; i++) begin
      a  = 7'($urandom_range(0, 127));
      nw = $urandom_range(1, 2);
      wq.delete();
      for (int k = 0; k < nw; k++) wq.push_back($urandom & dmask(8 * cfg_db(i)));
      do_write(i, a);
      do_read(i, 7'($urandom_range(0, 127)), $urandom_range(1, 2));
    end

    check_val("strobe_shape", 64'(clash_cnt), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/spi_slave_regif.md
# spi_slave_regif

Synthesizable, parametrised SPI slave that converts SPI frames into single-cycle register-file read/write strobes on the system clock. It samples `SCA_spi`, `CS_spi` and `MOSI_spi` on `clk`, decodes a header byte holding R/W and address, and then moves `DATA_BYTES` data bytes per word. Burst transfers auto-increment the address, and all four SPI modes are supported. It is the RTL counterpart of the `addapter_intf.SPISLAVE` behavioural model and sits behind the SPI adapter, in front of the block's register file.

## Interface
- `ADD_range`, 7: address width. The header is 1 R/W bit plus `ADD_range` bits, so `ADD_range` is fixed at 7 for a byte header.
- `DATA_BYTES`, 3: data bytes per word, from 1 to 4. `DW` = 8*`DATA_BYTES`.
- `SPI_MODE`, 0: SPI mode 0..3. `CPOL` = `SPI_MODE[1]`, `CPHA` = `SPI_MODE[0]`.
- `clk` in 1: system clock. All logic is on its rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `SCA_spi` in 1: SPI clock from the master. It is asynchronous to `clk` and runs at most `clk`/10.
- `CS_spi` in 1: chip select, active-low. It is asynchronous to `clk`.
- `MOSI_spi` in 1: master-to-slave data, MSB first.
- `MISO_spi` out 1: slave-to-master data, MSB first.
- `reg_addr` out `ADD_range`: word address for the current access.
- `reg_wdata` out `DW`: write data. Valid while `reg_wr`=1.
- `reg_wr` out 1: one-cycle write strobe.
- `reg_rd` out 1: one-cycle read strobe.
- `reg_rdata` in `DW`: read data. It must be valid on the cycle after `reg_rd`.
- `busy` out 1: high while a frame is open (`CS_spi` low and synchronised).
- `frame_err` out 1: one-cycle pulse when a frame is aborted.

## Operation
- **Input sync:** `SCA_spi`, `CS_spi` and `MOSI_spi` each pass through a 2-FF synchroniser.
  - Edge detection on the synchronised `SCA_spi` produces `lead_e` and `trail_e`. For `CPOL`=0 the leading edge is rising; for `CPOL`=1 it is falling.
  - Sample edge is `lead_e` if `CPHA`=0, otherwise `trail_e`. Shift edge is the other one.
- **Frame format:**
  - Header byte: bit7 = 1 means write, 0 means read. Bits [6:0] are the start address.
  - The header is followed by N×`DATA_BYTES` data bytes.
- **FSM states:** IDLE, HEADER, WDATA, RDATA.
  - IDLE → HEADER on a synchronised `CS_spi` falling edge. The bit counter and shift registers clear.
  - HEADER: 8 sample edges shift MOSI into `hdr`. On the 8th:
    - `reg_addr` ← `hdr[6:0]`.
    - Write: go to WDATA.
    - Read: pulse `reg_rd` and go to RDATA.
  - WDATA: `DW` sample edges shift MOSI into `wsr`. On the last bit:
    - `reg_wdata` ← `wsr`, and `reg_wr` pulses in the same cycle.
    - On the following cycle `reg_addr` ← `reg_addr`+1, wrapping modulo 2^`ADD_range`.
    - Bit counter resets and the FSM stays in WDATA (burst).
  - RDATA:
    - The cycle after `reg_rd`, `rsr` ← `reg_rdata`.
    - MISO presents `rsr[DW-1]`. Each shift edge shifts `rsr` left. MOSI is ignored.
    - After `DW` bits, `reg_addr` increments (wrap as above), `reg_rd` pulses again, and `rsr` reloads (burst).
- **MISO:**
  - Driven 0 in IDLE, HEADER and WDATA.
  - `CPHA`=0: the first data bit must be on MISO before the first data leading edge. `rsr` is therefore loaded before the trailing edge that ends the header, and its MSB is driven immediately on load.
  - `CPHA`=1: the MSB is driven on the first shift edge of the data phase.
- **CS rise (synchronised):** the FSM returns to IDLE from any state.
  - If it occurs mid-byte, or mid-word in WDATA/RDATA, `frame_err` pulses. No `reg_wr` is issued for the partial word.
  - A CS rise on an exact word boundary, or before any header bit, is clean: no `frame_err`.
- **Simultaneous events:** if a CS rise and a sample edge land on the same cycle, the CS rise wins. The sample is discarded.
- **Reset:** the asynchronous assert forces IDLE immediately, even mid-frame. No strobes are issued.

## Timing
- **Reset values:** `MISO_spi`=0, `reg_addr`=0, `reg_wdata`=0, `reg_wr`=0, `reg_rd`=0, `busy`=0, `frame_err`=0.
- **Input-to-action latency:** 3 `clk` cycles from an SPI pin edge (2 sync + 1 edge detect).
- **MISO:** updates within 4 `clk` of the shift edge, comfortably inside the ≥5-cycle half-period.
- **`reg_wr`:** pulses 3 `clk` after the SCLK edge carrying the last bit of a word.
- **`reg_rd`:** pulses 3 `clk` after the 8th header sample edge.
- **`reg_rdata`:** captured exactly 1 cycle after `reg_rd`. No wait states are supported.
- **`busy`:** rises/falls 2 cycles after the `CS_spi` fall/rise.
- **Strobes:** `reg_wr` and `reg_rd` are never high together, and each is at most 1 cycle wide.

## Test plan
- **Mode 0 write:** `DATA_BYTES`=3, frame 0xAA, 0xAA, 0xAA, 0xAA → `reg_wr` pulses once with `reg_addr`=0x2A and `reg_wdata`=0xAAAAAA. `frame_err`=0.
- **Mode 0 read:** header 0x15, `reg_rdata`=0xC3A55A → `reg_rd` pulses with addr 0x15. The master captures 0xC3A55A MSB-first.
- **Burst write with wrap:** header 0xFF (write, addr 0x7F) followed by 6 data bytes 0x010203, 0x040506 → writes 0x010203@0x7F and 0x040506@0x00.
- **Abort:** CS rises after 12 data bits of a write → no `reg_wr`, one `frame_err` pulse, FSM in IDLE. The next clean frame works normally.
- **All modes:** repeat the read and write scenarios for `SPI_MODE`=1, 2, 3 with `DATA_BYTES`=1 and 4 → same captured values. MISO is 0 outside RDATA.
- **Reset mid-frame:** assert `reset` low in the middle of the WDATA phase → all outputs return to reset values at once, no strobes, and a subsequent frame is decoded correctly.
